// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// rr_pick returns the first set request bit, searching upward from prio with wrap.
package arb_pkg;
    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } pick_t;

    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [ID_W-1:0]    prio);
        pick_t           p;
        logic [ID_W-1:0] idx;
        p = '0;
        // Walk from the lowest-priority slot up so the closest hit to prio lands last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = prio + ID_W'(i);
            if (req[idx]) begin
                p.found = 1'b1;
                p.id    = idx;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/decoder_24.sv
// 2-to-4 one-hot decoder used to expand the registered owner index.
module decoder_24
    import arb_pkg::*;
(
    input  logic [ID_W-1:0]    sel_i,
    output logic [NUM_REQ-1:0] onehot_o
);
    assign onehot_o = NUM_REQ'(1) << sel_i;
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded tenure under contention.
// All decisions are registered; gnt is the gated decode of the registered owner.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                gnt_valid
);
    localparam int              CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e          state_q;
    logic [ID_W-1:0]     gnt_id_q;
    logic [ID_W-1:0]     prio_q;
    logic                gnt_valid_q;
    logic [CNT_W-1:0]    hold_cnt_q;

    logic [NUM_REQ-1:0]  owner_oh;
    logic [NUM_REQ-1:0]  others;
    logic                owner_req;
    logic                expired;
    logic                rearb;
    pick_t               pick;

    decoder_24 u_dec (
        .sel_i    (gnt_id_q),
        .onehot_o (owner_oh)
    );

    always_comb begin
        owner_req = |(req & owner_oh);
        others    = req & ~owner_oh;
        expired   = (hold_cnt_q == HOLD_LAST) && (|others);
        rearb     = (state_q == ARB_IDLE) || !owner_req || expired;
        // While busy the owner is excluded; on release its bit is already clear.
        pick      = rr_pick((state_q == ARB_BUSY) ? others : req, prio_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_id_q    <= '0;
            prio_q      <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else if (rearb) begin
            hold_cnt_q <= '0;
            if (pick.found) begin
                state_q     <= ARB_BUSY;
                gnt_id_q    <= pick.id;
                prio_q      <= pick.id + ID_W'(1);
                gnt_valid_q <= 1'b1;
            end else begin
                // gnt_id_q intentionally keeps the last owner while idle.
                state_q     <= ARB_IDLE;
                gnt_valid_q <= 1'b0;
            end
        end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
    end

    assign gnt       = owner_oh & {NUM_REQ{gnt_valid_q}};
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench: directed vector table, contention sequence, then random
// traffic compared against a tenure/priority reference model.
module tb_rr_arbiter_4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int checks = 0;
    int failures = 0;

    // Reference state: owner index, next-priority client, cycles owned so far.
    int m_owner = 0, m_prio = 0, m_ten = 0;
    bit m_valid = 0;

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rn);
        logic [3:0] others;
        int w;
        if (!rn) begin
            m_owner = 0; m_prio = 0; m_ten = 0; m_valid = 0;
            return;
        end
        others = m_valid ? (r & ~(4'b0001 << m_owner)) : r;
        if (m_valid && r[m_owner] && !(m_ten >= MAX_HOLD && others != 0)) begin
            if (m_ten < MAX_HOLD) m_ten++;
            return;
        end
        w = search(others, m_prio);
        if (w < 0) begin
            m_valid = 0; m_ten = 0;
        end else begin
            m_owner = w; m_prio = (w + 1) % 4; m_ten = 1; m_valid = 1;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rn);
        req = r;
        rst_n = rn;
        @(posedge clk);
        model_step(r, rn);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rn;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [3:0] r;
        logic       rn;
        int         exp_o;

        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[4]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[5]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[7]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
        tbl[8]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
        tbl[9]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[12] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[13] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
        tbl[14] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[15] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[16] = '{1'b1, 4'b0110, 4'b0100, 2'd2, 1'b1};
        tbl[17] = '{1'b0, 4'b0110, 4'b0000, 2'd0, 1'b0};
        tbl[18] = '{1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[19] = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].req, tbl[i].rn);
            check($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            check($sformatf("vec%0d_id", i), int'(gnt_id), int'(tbl[i].id));
            check($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(tbl[i].vld));
        end

        // Sole requester keeps the grant well past MAX_HOLD.
        for (int c = 0; c < 21; c++) begin
            step(4'b0100, 1'b1);
            check($sformatf("single%0d_gnt", c), int'(gnt), 4);
            check($sformatf("single%0d_id", c), int'(gnt_id), 2);
        end
        step(4'b0000, 1'b1);
        check("single_release_valid", int'(gnt_valid), 0);

        // Full contention from reset: 0,1,2,3,0 each for MAX_HOLD cycles.
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("cont_reset_gnt", int'(gnt), 0);
        for (int c = 0; c < 5 * MAX_HOLD; c++) begin
            step(4'b1111, 1'b1);
            exp_o = (c / MAX_HOLD) % 4;
            check($sformatf("cont%0d_id", c), int'(gnt_id), exp_o);
            check($sformatf("cont%0d_gnt", c), int'(gnt), 1 << exp_o);
            check($sformatf("cont%0d_onehot", c), int'($onehot(gnt)), 1);
        end

        // Random traffic against the reference model.
        r = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            else if (m_valid && $urandom_range(0, 5) == 0) r[m_owner] = 1'b0;
            rn = ($urandom_range(0, 99) != 0);
            step(r, rn);
            check("rand_valid", int'(gnt_valid), int'(m_valid));
            check("rand_id", int'(gnt_id), m_owner);
            check("rand_gnt", int'(gnt), m_valid ? (1 << m_owner) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
